axi4_stream_fifo: RTL
=====================

Name: axi4_stream_fifo

Overview:
Synthesizable, parametrised AXI4-Stream FIFO carrying the full sideband set: TDATA, TSTRB, TKEEP, TID, TDEST, TUSER and TLAST. It sits between an AXI4-Stream master and slave in DUTs and in BFM-driven benches. It provides elastic buffering of configurable depth and an optional store-and-forward packet mode. It reports occupancy and whole-packet counts for monitors and flow-control logic.

Parameters:
N, 1, TDATA width in bytes; TSTRB and TKEEP are N bits.
I, 1, TID width in bits.
D, 1, TDEST width in bits.
U, 1, TUSER width in bits.
DEPTH, 16, entries; power of two, >= 2.
PACKET_MODE, 0, 0 = cut-through; 1 = store-and-forward on TLAST.

Ports:
ACLK  in  1  clock; all logic on rising edge.
ARESET  in  1  synchronous reset, active-high.
S_TVALID/S_TREADY  in/out  1/1  slave-side handshake.
S_TDATA S_TSTRB S_TKEEP S_TID S_TDEST S_TUSER S_TLAST  in  8N,N,N,I,D,U,1  slave-side payload.
M_TVALID/M_TREADY  out/in  1/1  master-side handshake.
M_TDATA M_TSTRB M_TKEEP M_TID M_TDEST M_TUSER M_TLAST  out  8N,N,N,I,D,U,1  master-side payload.
LEVEL  out  $clog2(DEPTH)+1  beats stored.
PKT_LEVEL  out  $clog2(DEPTH)+1  complete packets stored (TLAST beats stored).

Behaviour:
- Reset: ACLK and ARESET only; reset is synchronous and active-high.
  - While ARESET is high: S_TREADY=0, M_TVALID=0, LEVEL=0, PKT_LEVEL=0, pointers=0, M_ payload=0.
  - Reset asserted mid-packet discards all stored beats and any partial packet. No beat is emitted afterwards from pre-reset data.
- Push: occurs when S_TVALID && S_TREADY at a rising edge.
  - S_TREADY = !ARESET && (LEVEL < DEPTH), driven from registered state only.
  - No combinational path from M_TREADY to S_TREADY. When full, a simultaneous pop does not enable a push in the same cycle.
- Pop: occurs when M_TVALID && M_TREADY.
  - M_ payload is driven directly from the read-pointer entry (first-word fall-through).
  - Payload and M_TVALID must stay stable while M_TVALID && !M_TREADY.
- Latency: a beat pushed at edge k is visible with M_TVALID=1 after edge k (cycle k+1) in cut-through mode when the FIFO was empty. There is no same-cycle bypass.
- Cut-through mode: M_TVALID = (LEVEL != 0).
- Packet mode: M_TVALID = (LEVEL != 0) && (PKT_LEVEL != 0 || LEVEL == DEPTH).
  - The full-release term prevents deadlock for packets longer than DEPTH. Such packets degrade to cut-through for their remaining beats.
  - Once the first beat of a released packet is popped, M_TVALID follows LEVEL != 0 until that packet's TLAST is popped. This is tracked with an in-flight flag cleared on the TLAST pop.
- Counters:
  - LEVEL: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - PKT_LEVEL: +1 on push with S_TLAST, -1 on pop with M_TLAST. Both may occur in one cycle, giving a net of 0.
  - Neither counter may exceed DEPTH or go negative.
- Pointers: $clog2(DEPTH)+1 bits each. The MSB is the wrap bit. Full and empty are derived from the count and are consistent with pointer difference.
- Sideband: all fields are stored verbatim. TKEEP/TSTRB are not interpreted; null bytes are passed through unchanged.
- Storage may be flops or inferred distributed RAM. Read is asynchronous from the registered read pointer.

Decomposition:
- Package axi4_stream_pkg holds:
  - localparams for default N/I/D/U;
  - a parametrised payload struct type (data, strb, keep, id, dest, user, last), or a width function giving total payload bits 10N+I+D+U+1;
  - a function clog2_depth.
- Sub-module axi4_stream_fifo_mem holds simple dual-port storage of DEPTH x payload bits, with a synchronous write port and an asynchronous read port. Pointers, counters and handshake stay in the top module.

Test Plan:
- Reset then idle, DEPTH=16 -> S_TREADY=1 on the first cycle after ARESET drops; M_TVALID=0; LEVEL=0.
- Cut-through, push 16 beats with M_TREADY=0 -> LEVEL=16, S_TREADY=0. Then a 17th S_TVALID is held and not accepted. Then M_TREADY=1 drains beats 0..15 in order with all sideband fields intact.
- Continuous streaming with both sides always ready, 100 random beats -> LEVEL stays at 1 after the first beat, throughput is 1 beat/cycle, and the output matches the input.
- PACKET_MODE=1, push a 5-beat packet at 1 beat per 2 cycles with M_TREADY=1 -> M_TVALID stays 0 until the cycle after the TLAST push; then 5 consecutive beats; PKT_LEVEL goes 1->0.
- PACKET_MODE=1, DEPTH=4, 7-beat packet -> M_TVALID rises when LEVEL=4, and all 7 beats are delivered in order without deadlock.
- ARESET asserted for 1 cycle with LEVEL=6 and PKT_LEVEL=2 -> all outputs return to reset values next cycle; no stale beat appears afterwards.

Source files
------------

// File: rtl/axi4_stream_pkg.sv
// axi4_stream_pkg: default widths and sizing helpers shared by the AXI4-Stream FIFO files
package axi4_stream_pkg;
    localparam int N_DEF = 1;
    localparam int I_DEF = 1;
    localparam int D_DEF = 1;
    localparam int U_DEF = 1;
    function automatic int payload_bits(int n, int i, int d, int u);
        return 10 * n + i + d + u + 1;
    endfunction
    function automatic int clog2_depth(int depth);
        return $clog2(depth);
    endfunction
endpackage

// File: rtl/axi4_stream_fifo_mem.sv
// axi4_stream_fifo_mem: simple dual-port storage, synchronous write, asynchronous read
module axi4_stream_fifo_mem
    import axi4_stream_pkg::*;
#(
    parameter int W = 11,
    parameter int DEPTH = 16,
    localparam int AW = clog2_depth(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/axi4_stream_fifo.sv
// axi4_stream_fifo: first-word fall-through AXI4-Stream FIFO with optional store-and-forward release
module axi4_stream_fifo
    import axi4_stream_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int I = I_DEF,
    parameter int D = D_DEF,
    parameter int U = U_DEF,
    parameter int DEPTH = 16,
    parameter int PACKET_MODE = 0,
    localparam int AW = clog2_depth(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          ACLK,
    input  logic          ARESET,
    input  logic          S_TVALID,
    output logic          S_TREADY,
    input  logic [8*N-1:0] S_TDATA,
    input  logic [N-1:0]  S_TSTRB,
    input  logic [N-1:0]  S_TKEEP,
    input  logic [I-1:0]  S_TID,
    input  logic [D-1:0]  S_TDEST,
    input  logic [U-1:0]  S_TUSER,
    input  logic          S_TLAST,
    output logic          M_TVALID,
    input  logic          M_TREADY,
    output logic [8*N-1:0] M_TDATA,
    output logic [N-1:0]  M_TSTRB,
    output logic [N-1:0]  M_TKEEP,
    output logic [I-1:0]  M_TID,
    output logic [D-1:0]  M_TDEST,
    output logic [U-1:0]  M_TUSER,
    output logic          M_TLAST,
    output logic [CW-1:0] LEVEL,
    output logic [CW-1:0] PKT_LEVEL
);
    localparam int W = payload_bits(N, I, D, U);
    logic [CW-1:0] wptr, rptr, level, pkt_level;
    logic in_flight, full, avail, push, pop;
    logic [W-1:0] wdata, rdata;
    assign full = level == CW'(DEPTH);
    assign S_TREADY = !ARESET && !full;
    // full release keeps packets longer than DEPTH flowing; in_flight holds a started packet open
    assign avail = level != '0 && (PACKET_MODE == 0 || pkt_level != '0 || full || in_flight);
    assign M_TVALID = !ARESET && avail;
    assign push = S_TVALID && S_TREADY;
    assign pop = M_TVALID && M_TREADY;
    assign wdata = {S_TDATA, S_TSTRB, S_TKEEP, S_TID, S_TDEST, S_TUSER, S_TLAST};
    assign {M_TDATA, M_TSTRB, M_TKEEP, M_TID, M_TDEST, M_TUSER, M_TLAST} = ARESET ? '0 : rdata;
    assign LEVEL = ARESET ? '0 : level;
    assign PKT_LEVEL = ARESET ? '0 : pkt_level;
    axi4_stream_fifo_mem #(.W(W), .DEPTH(DEPTH)) u_mem (
        .clk(ACLK),
        .we(push),
        .waddr(wptr[AW-1:0]),
        .wdata(wdata),
        .raddr(rptr[AW-1:0]),
        .rdata(rdata)
    );
    always_ff @(posedge ACLK)
        if (ARESET) begin
            wptr <= '0;
            rptr <= '0;
            level <= '0;
            pkt_level <= '0;
            in_flight <= 1'b0;
        end else begin
            wptr <= wptr + CW'(push);
            rptr <= rptr + CW'(pop);
            level <= level + CW'(push) - CW'(pop);
            pkt_level <= pkt_level + CW'(push && S_TLAST) - CW'(pop && rdata[0]);
            if (pop) in_flight <= !rdata[0];
        end
    always_ff @(posedge ACLK)
        if (!ARESET) assert (level == wptr - rptr);
endmodule
